// File: rtl/stream_arb2_rr.sv
// Two-input packet-aware round-robin arbiter feeding a one-entry registered output stage.
// A port that wins keeps the grant until its last beat is accepted, so packets never interleave.
module stream_arb2_rr #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a_data,
  input  logic             a_valid,
  input  logic             a_last,
  output logic             a_ready,
  input  logic [WIDTH-1:0] b_data,
  input  logic             b_valid,
  input  logic             b_last,
  output logic             b_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             sel
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   prio, prio_nxt;
  logic   grant_a, grant_b;
  logic   accept_a, accept_b;
  logic   load_ok;

  // The output register can take a new beat when empty or draining this cycle.
  assign load_ok = !out_valid | out_ready;
  assign a_ready = rst_n & grant_a & load_ok;
  assign b_ready = rst_n & grant_b & load_ok;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  always_comb begin
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    accept_a  = 1'b0;
    accept_b  = 1'b0;
    state_nxt = state;
    prio_nxt  = prio;

    case (state)
      IDLE: begin
        if (a_valid && b_valid) begin
          grant_a = !prio;
          grant_b = prio;
        end else begin
          grant_a = a_valid;
          grant_b = b_valid;
        end
      end
      LOCK_A:  grant_a = 1'b1;
      LOCK_B:  grant_b = 1'b1;
      default: ;
    endcase

    accept_a = rst_n & a_valid & grant_a & load_ok;
    accept_b = rst_n & b_valid & grant_b & load_ok;

    // Priority flips only when a packet completes, handing the next tie to the other port.
    if (accept_a) begin
      if (a_last) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b1;
      end else begin
        state_nxt = LOCK_A;
      end
    end else if (accept_b) begin
      if (b_last) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b0;
      end else begin
        state_nxt = LOCK_B;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      sel       <= 1'b0;
    end else if (accept_a) begin
      out_valid <= 1'b1;
      out_data  <= a_data;
      out_last  <= a_last;
      sel       <= 1'b0;
    end else if (accept_b) begin
      out_valid <= 1'b1;
      out_data  <= b_data;
      out_last  <= b_last;
      sel       <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_arb2_rr.sv
// Scoreboard bench for stream_arb2_rr: a packet-level arbitration model predicts readies and
// queues expected output beats; an independent monitor checks whatever the output presents.
module tb_stream_arb2_rr;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [WIDTH-1:0] a_data = '0, b_data = '0;
  logic             a_valid = 1'b0, a_last = 1'b0, b_valid = 1'b0, b_last = 1'b0;
  logic             a_ready, b_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid, out_last, sel;
  logic             out_ready = 1'b0;

  always #5 clk = ~clk;

  stream_arb2_rr #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_data(a_data), .a_valid(a_valid), .a_last(a_last), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_last(b_last), .b_ready(b_ready),
    .out_data(out_data), .out_valid(out_valid), .out_last(out_last),
    .out_ready(out_ready), .sel(sel)
  );

  typedef struct packed {logic [WIDTH-1:0] data; logic last;} beat_t;
  typedef struct packed {logic [WIDTH-1:0] data; logic last; logic src;} exp_t;

  beat_t aq[$], bq[$];
  exp_t  sb[$];
  int    tests = 0, fails = 0;
  bit    mon_en = 1'b0;
  bit    a_pres = 1'b0, b_pres = 1'b0;
  int    pct_a = 100, pct_b = 100, pct_rdy = 100;
  int    owner = 0;
  bit    pref = 1'b0;
  bit    rst_drive = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock of stimulus: present beats, predict readies, then record what was accepted.
  task automatic applyStimulus();
    bit    lok, exp_ar, exp_br, acc_a, acc_b;
    int    gnt;
    beat_t tmp;
    exp_t  e;
    @(negedge clk);
    rst_n = !rst_drive;
    if (!a_pres && aq.size() > 0 && $urandom_range(99) < pct_a) a_pres = 1'b1;
    if (!b_pres && bq.size() > 0 && $urandom_range(99) < pct_b) b_pres = 1'b1;
    a_valid   = a_pres;
    a_data    = a_pres ? aq[0].data : WIDTH'($urandom);
    a_last    = a_pres ? aq[0].last : 1'($urandom);
    b_valid   = b_pres;
    b_data    = b_pres ? bq[0].data : WIDTH'($urandom);
    b_last    = b_pres ? bq[0].last : 1'($urandom);
    out_ready = ($urandom_range(99) < pct_rdy);
    #1;
    lok = (sb.size() == 0) || out_ready;
    gnt = -1;
    if (owner == 1) gnt = 0;
    else if (owner == 2) gnt = 1;
    else if (a_valid && b_valid) gnt = int'(pref);
    else if (a_valid) gnt = 0;
    else if (b_valid) gnt = 1;
    exp_ar = rst_n && (gnt == 0) && lok;
    exp_br = rst_n && (gnt == 1) && lok;
    checkOutput("a_ready", 32'(a_ready), 32'(exp_ar));
    checkOutput("b_ready", 32'(b_ready), 32'(exp_br));
    acc_a = exp_ar && a_valid;
    acc_b = exp_br && b_valid;
    @(posedge clk);
    #1;
    if (!rst_n) begin
      sb.delete(); aq.delete(); bq.delete();
      owner = 0; pref = 1'b0; a_pres = 1'b0; b_pres = 1'b0;
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_data", 32'(out_data), 32'd0);
      checkOutput("rst_out_last", 32'(out_last), 32'd0);
      checkOutput("rst_sel", 32'(sel), 32'd0);
    end else if (acc_a) begin
      tmp = aq.pop_front();
      e.data = tmp.data; e.last = tmp.last; e.src = 1'b0;
      sb.push_back(e);
      if (tmp.last) begin owner = 0; pref = 1'b1; end else owner = 1;
      a_pres = 1'b0;
    end else if (acc_b) begin
      tmp = bq.pop_front();
      e.data = tmp.data; e.last = tmp.last; e.src = 1'b1;
      sb.push_back(e);
      if (tmp.last) begin owner = 0; pref = 1'b0; end else owner = 2;
      b_pres = 1'b0;
    end
  endtask

  task automatic doReset();
    rst_drive = 1'b1;
    repeat (2) applyStimulus();
    rst_drive = 1'b0;
  endtask

  task automatic pushBeat(input bit port, input int d, input bit l);
    beat_t b;
    b.data = WIDTH'(d);
    b.last = l;
    if (port) bq.push_back(b); else aq.push_back(b);
  endtask

  task automatic runUntilEmpty(input int maxc);
    int n = 0;
    while ((aq.size() > 0 || bq.size() > 0 || sb.size() > 0) && n < maxc) begin
      applyStimulus();
      n++;
    end
    if (aq.size() > 0 || bq.size() > 0 || sb.size() > 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL timeout: %0d beats still pending after %0d cycles, expected 0",
               aq.size() + bq.size() + sb.size(), maxc);
    end
  endtask

  // Monitor: checks the beat held on the output against the scoreboard head every cycle.
  initial begin
    forever begin
      @(negedge clk);
      #2;
      if (mon_en) begin
        checkOutput("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (out_valid && sb.size() > 0) begin
          checkOutput("out_data", 32'(out_data), 32'(sb[0].data));
          checkOutput("out_last", 32'(out_last), 32'(sb[0].last));
          checkOutput("sel", 32'(sel), 32'(sb[0].src));
        end
        if (sb.size() > 0 && out_ready) sb.delete(0);
      end
    end
  end

  initial begin
    doReset();
    mon_en = 1'b1;

    pushBeat(0, 5, 1'b1);
    runUntilEmpty(20);

    doReset();
    for (int i = 0; i < 3; i++) begin
      pushBeat(0, i + 1, 1'b1);
      pushBeat(1, 9 - i, 1'b1);
    end
    runUntilEmpty(30);

    for (int i = 0; i < 3; i++) pushBeat(0, 10 + i, i == 2);
    pushBeat(1, 4, 1'b1);
    runUntilEmpty(30);

    for (int i = 0; i < 3; i++) pushBeat(0, 3 + i, i == 2);
    pushBeat(1, 6, 1'b1);
    applyStimulus();
    pct_rdy = 0;
    repeat (4) applyStimulus();
    pct_rdy = 100;
    runUntilEmpty(30);

    for (int i = 0; i < 3; i++) pushBeat(0, 12 + i, i == 2);
    applyStimulus();
    rst_drive = 1'b1;
    applyStimulus();
    rst_drive = 1'b0;
    pushBeat(1, 11, 1'b1);
    runUntilEmpty(20);

    for (int i = 0; i < 8; i++) pushBeat(0, i, 1'b1);
    runUntilEmpty(30);

    pct_a = 60; pct_b = 60; pct_rdy = 70;
    for (int i = 0; i < 2000; i++) begin
      if (aq.size() < 4 && $urandom_range(3) == 0) begin
        int len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) pushBeat(0, int'($urandom_range(15)), k == len - 1);
      end
      if (bq.size() < 4 && $urandom_range(3) == 0) begin
        int len = $urandom_range(1, 3);
        for (int k = 0; k < len; k++) pushBeat(1, int'($urandom_range(15)), k == len - 1);
      end
      applyStimulus();
    end
    pct_a = 100; pct_b = 100; pct_rdy = 100;
    runUntilEmpty(100);
    applyStimulus();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
